// File: rtl/mem_access.sv
// MEM-stage data-memory controller.
// Issues one dmem request per EX/MEM load/store and stalls the pipeline until
// the response arrives. Load data is registered for writeback. The block also
// keeps saturating load/store/stall counters and misalignment/timeout flags.
module mem_access #(
    parameter int MAX_WAIT = 64,
    parameter int COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata_raw,
    input  logic [3:0]         byte_en_in,
    input  logic               ext_stall,
    input  logic               dmem_resp,
    input  logic [31:0]        dmem_rdata,
    output logic [31:0]        dmem_addr,
    output logic               dmem_read,
    output logic               dmem_write,
    output logic [3:0]         dmem_wmask,
    output logic [31:0]        dmem_wdata,
    output logic               stall_mem,
    output logic [31:0]        load_data,
    output logic               load_valid,
    output logic               err_misalign,
    output logic               err_timeout,
    output logic [COUNT_W-1:0] load_cnt,
    output logic [COUNT_W-1:0] store_cnt,
    output logic [COUNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam int            TW         = $clog2(MAX_WAIT + 1);
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(MAX_WAIT);

    state_t        state;
    logic [TW-1:0] wait_cnt;

    // Request captured at issue so WAIT drives exactly what was issued.
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_mask;
    logic          req_is_read;

    logic          is_read;
    logic          is_write;
    logic          op;
    logic          misaligned;
    logic          issue;
    logic          in_wait;
    logic [31:0]   shifted_wdata;

    // Decode the EX/MEM operation and decide whether it may issue this cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_read       = valid_in & mem_read;
        is_write      = valid_in & mem_write & ~mem_read;
        op            = is_read | is_write;
        misaligned    = 1'b0;
        case (funct3[1:0])
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            2'b01:   misaligned = addr[0];
            default: misaligned = 1'b0;
        endcase
        // Reset masks the request so nothing leaves the block while rst is low.
        issue         = rst & (state == IDLE) & op & ~misaligned;
        in_wait       = rst & (state == WAIT);
        shifted_wdata = wdata_raw << {addr[1:0], 3'b000};
    end

    // Drive the dmem handshake and pipeline stall from the current state.
    always_comb begin
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_wmask = 4'd0;
        if (issue) begin
            dmem_read  = is_read;
            dmem_write = is_write;
            dmem_addr  = {addr[31:2], 2'b00};
            if (is_write) begin
                dmem_wdata = shifted_wdata;
                dmem_wmask = byte_en_in;
            end
        end else if (in_wait) begin
            dmem_read  = req_is_read;
            dmem_write = ~req_is_read;
            dmem_addr  = req_addr;
            if (!req_is_read) begin
                dmem_wdata = req_wdata;
                dmem_wmask = req_mask;
            end
        end
        stall_mem = issue | (in_wait & ~dmem_resp);
    end

    // Sequence IDLE/WAIT/DONE, capture load data and maintain counters and flags.
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_mask     <= '0;
            req_is_read  <= 1'b0;
            load_data    <= '0;
            load_valid   <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            load_cnt     <= '0;
            store_cnt    <= '0;
            stall_cnt    <= '0;
        end else begin
            load_valid   <= 1'b0;
            err_misalign <= (state == IDLE) && op && misaligned;
            if (stall_mem && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + COUNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (issue) begin
                        state       <= WAIT;
                        wait_cnt    <= '0;
                        req_addr    <= {addr[31:2], 2'b00};
                        req_is_read <= is_read;
                        req_wdata   <= is_write ? shifted_wdata : 32'd0;
                        req_mask    <= is_write ? byte_en_in : 4'd0;
                    end
                end
                WAIT: begin
                    if (dmem_resp) begin
                        state <= ext_stall ? DONE : IDLE;
                        if (req_is_read) begin
                            load_data  <= dmem_rdata;
                            load_valid <= 1'b1;
                            if (load_cnt != '1) begin
                                load_cnt <= load_cnt + COUNT_W'(1);
                            end
                        end else if (store_cnt != '1) begin
                            store_cnt <= store_cnt + COUNT_W'(1);
                        end
                    end else begin
                        if (wait_cnt != WAIT_LIMIT) begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                        if (wait_cnt == WAIT_LIMIT - TW'(1)) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // The completed op may still sit in EX/MEM; wait for it to leave.
                    if (!ext_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access.
// Each transaction is predicted from the access rules: misalignment by access
// size, request/stall timing from the response delay, store lane shifting,
// counters as running tallies and a sticky timeout once the response is late.
module tb_mem_access;

    localparam int MAXW = 8;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          mem_read;
    logic          mem_write;
    logic [2:0]    funct3;
    logic [31:0]   addr;
    logic [31:0]   wdata_raw;
    logic [3:0]    byte_en_in;
    logic          ext_stall;
    logic          dmem_resp;
    logic [31:0]   dmem_rdata;
    logic [31:0]   dmem_addr;
    logic          dmem_read;
    logic          dmem_write;
    logic [3:0]    dmem_wmask;
    logic [31:0]   dmem_wdata;
    logic          stall_mem;
    logic [31:0]   load_data;
    logic          load_valid;
    logic          err_misalign;
    logic          err_timeout;
    logic [CW-1:0] load_cnt;
    logic [CW-1:0] store_cnt;
    logic [CW-1:0] stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    int exp_load    = 0;
    int exp_store   = 0;
    int exp_stall   = 0;
    bit exp_timeout = 1'b0;

    mem_access #(.MAX_WAIT(MAXW), .COUNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .wdata_raw    (wdata_raw),
        .byte_en_in   (byte_en_in),
        .ext_stall    (ext_stall),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .dmem_addr    (dmem_addr),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .stall_mem    (stall_mem),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .load_cnt     (load_cnt),
        .store_cnt    (store_cnt),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
    function automatic bit misaligned_rule(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b010:         return a[1:0] != 2'b00;
            3'b001, 3'b101: return a[0];
            default:        return 1'b0;
        endcase
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_load_cnt"},  load_cnt,  32'(exp_load));
        check({tag, "_store_cnt"}, store_cnt, 32'(exp_store));
        check({tag, "_stall_cnt"}, stall_cnt, 32'(exp_stall));
    endtask

    task automatic check_no_request(input string tag);
        check({tag, "_rd"},    32'(dmem_read),  32'd0);
        check({tag, "_wr"},    32'(dmem_write), 32'd0);
        check({tag, "_stall"}, 32'(stall_mem),  32'd0);
    endtask

    // One EX/MEM instruction: delay = WAIT cycles without response before the
    // response cycle, hold = cycles ext_stall keeps the instruction after it.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic vld,
                          input int delay, input int hold);
        logic        is_ld;
        logic        is_st;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_mask;
        is_ld     = vld & rd;
        is_st     = vld & wr & ~rd;
        exp_addr  = {a[31:2], 2'b00};
        exp_wdata = is_st ? (wd << (8 * int'(a[1:0]))) : 32'd0;
        exp_mask  = is_st ? be : 4'd0;
        rdata     = 32'd0;

        @(negedge clk);
        valid_in   = vld;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        wdata_raw  = wd;
        byte_en_in = be;
        ext_stall  = 1'b0;
        dmem_resp  = 1'b0;
        #1;

        if (!is_ld && !is_st) begin
            check_no_request("nop");
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            check("nop_misalign", 32'(err_misalign), 32'd0);
            return;
        end

        if (misaligned_rule(f3, a)) begin
            check_no_request("mis");
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            check("mis_pulse", 32'(err_misalign), 32'd1);
            check_counters("mis");
            @(negedge clk);
            #1;
            check("mis_pulse_end", 32'(err_misalign), 32'd0);
            return;
        end

        check("iss_rd",    32'(dmem_read),  32'(is_ld));
        check("iss_wr",    32'(dmem_write), 32'(is_st));
        check("iss_addr",  dmem_addr,       exp_addr);
        check("iss_wdata", dmem_wdata,      exp_wdata);
        check("iss_wmask", 32'(dmem_wmask), 32'(exp_mask));
        check("iss_stall", 32'(stall_mem),  32'd1);
        exp_stall++;

        for (int w = 0; w <= delay; w++) begin
            @(negedge clk);
            dmem_rdata = $urandom;
            if (w == delay) begin
                dmem_resp = 1'b1;
                rdata     = dmem_rdata;
                ext_stall = (hold > 0);
            end
            #1;
            if (w >= MAXW) exp_timeout = 1'b1;
            check("wait_rd",      32'(dmem_read),   32'(is_ld));
            check("wait_wr",      32'(dmem_write),  32'(is_st));
            check("wait_addr",    dmem_addr,        exp_addr);
            check("wait_wdata",   dmem_wdata,       exp_wdata);
            check("wait_wmask",   32'(dmem_wmask),  32'(exp_mask));
            check("wait_stall",   32'(stall_mem),   32'(w != delay));
            check("wait_timeout", 32'(err_timeout), 32'(exp_timeout));
            if (w != delay) exp_stall++;
        end
        if (is_ld) exp_load++;
        else       exp_store++;

        // First cycle after the response: DONE if held, else back in IDLE.
        @(negedge clk);
        dmem_resp = 1'b0;
        ext_stall = (hold > 1);
        valid_in  = (hold > 0);
        #1;
        check("post_load_valid", 32'(load_valid), 32'(is_ld));
        if (is_ld) check("post_load_data", load_data, rdata);
        check_no_request("post");
        check_counters("post");
        for (int h = 2; h <= hold; h++) begin
            @(negedge clk);
            ext_stall = (h < hold);
            #1;
            check_no_request("done");
            check("done_load_valid", 32'(load_valid), 32'd0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b0;
        valid_in  = 1'b0;
        dmem_resp = 1'b0;
        ext_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_load    = 0;
        exp_store   = 0;
        exp_stall   = 0;
        exp_timeout = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        valid_in   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'd0;
        addr       = 32'd0;
        wdata_raw  = 32'd0;
        byte_en_in = 4'd0;
        ext_stall  = 1'b0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_err_misalign", 32'(err_misalign), 32'd0);
        check_counters("rst");
        check_no_request("rst");
        rst = 1'b1;

        // Directed: lw with response 3 cycles after issue.
        run_op(1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'd0, 4'd0, 1'b1, 2, 0);
        check("lw_stall_cnt", stall_cnt, 32'd3);
        check("lw_load_cnt", load_cnt, 32'd1);
        // Directed: sb to the top byte lane.
        run_op(1'b0, 1'b1, 3'b000, 32'h1000_0003, 32'h0000_00AB, 4'b1000, 1'b1, 0, 0);
        check("sb_store_cnt", store_cnt, 32'd1);
        // Directed: lw answered on the 2nd WAIT cycle while ext_stall holds 2 cycles.
        run_op(1'b1, 1'b0, 3'b010, 32'h1000_0008, 32'd0, 4'd0, 1'b1, 1, 2);
        // Directed: misaligned lh.
        run_op(1'b1, 1'b0, 3'b001, 32'h2000_0001, 32'd0, 4'd0, 1'b1, 0, 0);
        // Directed: read and write both high behaves as a load.
        run_op(1'b1, 1'b1, 3'b010, 32'h3000_0010, 32'h1234_5678, 4'hF, 1'b1, 1, 0);

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            logic        rd;
            logic        wr;
            logic        vld;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [2:0]  load_f3s [5];
            load_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            rd  = $urandom_range(0, 1) == 1;
            wr  = rd ? ($urandom_range(0, 7) == 0) : 1'b1;
            vld = $urandom_range(0, 9) != 0;
            f3  = rd ? load_f3s[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a   = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            run_op(rd, wr, f3, a, $urandom, 4'($urandom), vld,
                   $urandom_range(0, 6), $urandom_range(0, 2));
        end

        // Timeout: no response for well past MAX_WAIT WAIT cycles, then respond.
        run_op(1'b1, 1'b0, 3'b010, 32'h4000_0000, 32'd0, 4'd0, 1'b1, MAXW + 3, 0);
        check("timeout_sticky", 32'(err_timeout), 32'd1);
        @(negedge clk);
        #1;
        check("timeout_held", 32'(err_timeout), 32'd1);

        // Reset for one cycle in the middle of WAIT; a late response is ignored.
        @(negedge clk);
        valid_in  = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h5000_0000;
        #1;
        check("mid_issue", 32'(dmem_read), 32'd1);
        @(negedge clk);
        #1;
        check("mid_wait", 32'(stall_mem), 32'd1);
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        exp_load    = 0;
        exp_store   = 0;
        exp_stall   = 0;
        exp_timeout = 1'b0;
        #1;
        check_no_request("mid_rst");
        check_counters("mid_rst");
        check("mid_rst_timeout", 32'(err_timeout), 32'd0);
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        check("mid_rst_load_valid", 32'(load_valid), 32'd0);
        check("mid_rst_load_data", load_data, 32'd0);
        check_counters("mid_rst_late");

        // Block still works after the reset.
        run_op(1'b1, 1'b0, 3'b100, 32'h6000_0001, 32'd0, 4'd0, 1'b1, 0, 0);
        apply_reset();
        #1;
        check_counters("final_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard bound so a wedged run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
